// File: rtl/wave_recorder_if.sv
// Control, sample-stream and main-memory write signals of the wave recorder.
// The recorder sits on the slave side; the UI/stream/memory side uses master.
interface wave_recorder_if #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int WW_WIDTH     = 18,
   parameter int DECIM_WIDTH  = 4
);
   logic                    arm_in;
   logic                    abort_in;
   logic [WW_WIDTH-1:0]     wave_width_in;
   logic [DECIM_WIDTH-1:0]  decim_in;
   logic                    trig_en_in;
   logic [SAMPLE_WIDTH-1:0] threshold_in;
   logic [SAMPLE_WIDTH-1:0] sample_in;
   logic                    sample_valid_in;
   logic [WW_WIDTH-1:0]     mem_addr_out;
   logic [SAMPLE_WIDTH-1:0] mem_data_out;
   logic                    mem_we_out;
   logic                    busy_out;
   logic                    done_trig_out;
   logic [WW_WIDTH-1:0]     length_out;

   modport slave (
      input  arm_in, abort_in, wave_width_in, decim_in, trig_en_in,
             threshold_in, sample_in, sample_valid_in,
      output mem_addr_out, mem_data_out, mem_we_out, busy_out,
             done_trig_out, length_out
   );

   modport master (
      output arm_in, abort_in, wave_width_in, decim_in, trig_en_in,
             threshold_in, sample_in, sample_valid_in,
      input  mem_addr_out, mem_data_out, mem_we_out, busy_out,
             done_trig_out, length_out
   );
endinterface

// File: rtl/wave_recorder.sv
// Records a decimated, optionally threshold-triggered slice of a signed sample
// stream into main wave memory and pulses done so the wave loader refreshes.
module wave_recorder #(
   parameter int SAMPLE_WIDTH   = 16,
   parameter int WW_WIDTH       = 18,
   parameter int MMEM_MAX_DEPTH = 200000,
   parameter int DECIM_WIDTH    = 4
) (
   input  logic           clk_in,
   input  logic           rst_n_in,
   wave_recorder_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RECORD, S_DONE} state_t;

   localparam logic [WW_WIDTH-1:0] MAX_LEN = WW_WIDTH'(MMEM_MAX_DEPTH);

   state_t                  state_q, state_d;
   logic [WW_WIDTH-1:0]     target_q, target_d;
   logic [WW_WIDTH-1:0]     addr_q, addr_d;
   logic [DECIM_WIDTH-1:0]  decim_q, decim_d;
   logic [DECIM_WIDTH-1:0]  dcnt_q, dcnt_d;
   logic [SAMPLE_WIDTH-1:0] prev_q, prev_d;
   logic                    prev_valid_q, prev_valid_d;
   logic                    mem_we_q, mem_we_d;
   logic [WW_WIDTH-1:0]     mem_addr_q, mem_addr_d;
   logic [SAMPLE_WIDTH-1:0] mem_data_q, mem_data_d;
   logic                    done_q, done_d;
   logic [WW_WIDTH-1:0]     length_q, length_d;

   logic [WW_WIDTH-1:0]     clamped_len;
   logic                    last_addr;
   logic                    trig_hit;

   always_comb begin
      clamped_len = (bus.wave_width_in > MAX_LEN) ? MAX_LEN : bus.wave_width_in;
      last_addr   = (addr_q == target_q - WW_WIDTH'(1));
      trig_hit    = prev_valid_q &&
                    ($signed(prev_q) < $signed(bus.threshold_in)) &&
                    ($signed(bus.sample_in) >= $signed(bus.threshold_in));
   end

   always_comb begin
      state_d      = state_q;
      target_d     = target_q;
      addr_d       = addr_q;
      decim_d      = decim_q;
      dcnt_d       = dcnt_q;
      prev_d       = prev_q;
      prev_valid_d = prev_valid_q;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      done_d       = 1'b0;
      length_d     = length_q;

      case (state_q)
         S_IDLE: begin
            if (bus.arm_in && !bus.abort_in) begin
               target_d     = clamped_len;
               decim_d      = bus.decim_in;
               addr_d       = '0;
               dcnt_d       = '0;
               prev_valid_d = 1'b0;
               if (clamped_len == '0)
                  state_d = S_DONE;
               else if (bus.trig_en_in)
                  state_d = S_ARMED;
               else
                  state_d = S_RECORD;
            end
         end

         S_ARMED: begin
            if (bus.abort_in) begin
               state_d = S_IDLE;
            end else if (bus.sample_valid_in) begin
               prev_d       = bus.sample_in;
               prev_valid_d = 1'b1;
               if (trig_hit) begin
                  mem_we_d   = 1'b1;
                  mem_addr_d = addr_q;
                  mem_data_d = bus.sample_in;
                  addr_d     = addr_q + WW_WIDTH'(1);
                  // The triggering sample occupies decimation slot 0.
                  dcnt_d     = (decim_q == '0) ? '0 : DECIM_WIDTH'(1);
                  state_d    = last_addr ? S_DONE : S_RECORD;
               end
            end
         end

         S_RECORD: begin
            if (bus.abort_in) begin
               state_d = S_IDLE;
            end else if (bus.sample_valid_in) begin
               dcnt_d = (dcnt_q == decim_q) ? '0 : dcnt_q + DECIM_WIDTH'(1);
               if (dcnt_q == '0) begin
                  mem_we_d   = 1'b1;
                  mem_addr_d = addr_q;
                  mem_data_d = bus.sample_in;
                  addr_d     = addr_q + WW_WIDTH'(1);
                  if (last_addr)
                     state_d = S_DONE;
               end
            end
         end

         S_DONE: begin
            done_d   = 1'b1;
            length_d = target_q;
            state_d  = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q      <= S_IDLE;
         target_q     <= '0;
         addr_q       <= '0;
         decim_q      <= '0;
         dcnt_q       <= '0;
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         done_q       <= 1'b0;
         length_q     <= '0;
      end else begin
         state_q      <= state_d;
         target_q     <= target_d;
         addr_q       <= addr_d;
         decim_q      <= decim_d;
         dcnt_q       <= dcnt_d;
         prev_q       <= prev_d;
         prev_valid_q <= prev_valid_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         done_q       <= done_d;
         length_q     <= length_d;
      end
   end

   assign bus.mem_we_out    = mem_we_q;
   assign bus.mem_addr_out  = mem_addr_q;
   assign bus.mem_data_out  = mem_data_q;
   assign bus.done_trig_out = done_q;
   assign bus.length_out    = length_q;
   assign bus.busy_out      = (state_q == S_ARMED) || (state_q == S_RECORD);

endmodule

// File: tb/tb_wave_recorder.sv
// Scoreboard bench for wave_recorder: expected writes are queued as samples
// are driven and matched (address, data, cycle) as the write port fires.
module tb_wave_recorder;
   localparam int SW   = 16;
   localparam int WW   = 18;
   localparam int MAXD = 16;
   localparam int DW   = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wave_recorder_if #(.SAMPLE_WIDTH(SW), .WW_WIDTH(WW), .DECIM_WIDTH(DW)) bus ();

   wave_recorder #(
      .SAMPLE_WIDTH(SW), .WW_WIDTH(WW), .MMEM_MAX_DEPTH(MAXD), .DECIM_WIDTH(DW)
   ) dut (
      .clk_in(clk), .rst_n_in(rst_n), .bus(bus)
   );

   typedef struct {
      logic [WW-1:0] addr;
      logic [SW-1:0] data;
      int            cyc;
   } wr_t;

   wr_t sb[$];
   int  checks = 0;
   int  errors = 0;
   int  ncyc = 0;
   int  done_cnt = 0;
   int  last_done_cyc = -1;

   // Write-port monitor: every write must match the head of the scoreboard.
   always @(negedge clk) begin
      wr_t e;
      ncyc = ncyc + 1;
      if (bus.mem_we_out === 1'b1) begin
         checks = checks + 1;
         if (sb.size() == 0) begin
            errors = errors + 1;
            $display("FAIL write_unexpected: got addr=%0d data=%0d at cyc %0d, none expected",
                     bus.mem_addr_out, $signed(bus.mem_data_out), ncyc);
         end else begin
            e = sb.pop_front();
            if (bus.mem_addr_out !== e.addr || bus.mem_data_out !== e.data || ncyc != e.cyc) begin
               errors = errors + 1;
               $display("FAIL write: got addr=%0d data=%0d cyc=%0d, want addr=%0d data=%0d cyc=%0d",
                        bus.mem_addr_out, $signed(bus.mem_data_out), ncyc,
                        e.addr, $signed(e.data), e.cyc);
            end else begin
               $display("write addr=%0d data=%0d cyc=%0d ok", e.addr, $signed(e.data), ncyc);
            end
         end
      end
      if (bus.done_trig_out === 1'b1) begin
         done_cnt      = done_cnt + 1;
         last_done_cyc = ncyc;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.arm_in          = 1'b0;
      bus.abort_in        = 1'b0;
      bus.wave_width_in   = '0;
      bus.decim_in        = '0;
      bus.trig_en_in      = 1'b0;
      bus.threshold_in    = '0;
      bus.sample_in       = '0;
      bus.sample_valid_in = 1'b0;
   endtask

   task automatic arm(input int width, input int decim, input logic trig, input int thr);
      bus.arm_in        = 1'b1;
      bus.wave_width_in = WW'(width);
      bus.decim_in      = DW'(decim);
      bus.trig_en_in    = trig;
      bus.threshold_in  = SW'(thr);
      tick();
      bus.arm_in = 1'b0;
   endtask

   task automatic send(input int s, input logic exp, input int addr);
      bus.sample_in       = SW'(s);
      bus.sample_valid_in = 1'b1;
      if (exp) sb.push_back('{addr: WW'(addr), data: SW'(s), cyc: ncyc + 1});
      tick();
      bus.sample_valid_in = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      #12;
      checks = checks + 1;
      if ({bus.mem_we_out, bus.done_trig_out, bus.busy_out, bus.mem_addr_out,
           bus.mem_data_out, bus.length_out} !== '0) begin
         errors = errors + 1;
         $display("FAIL reset_outputs: we=%b done=%b busy=%b addr=%0d data=%0d len=%0d, want all 0",
                  bus.mem_we_out, bus.done_trig_out, bus.busy_out, bus.mem_addr_out,
                  bus.mem_data_out, bus.length_out);
      end
      rst_n = 1'b1;
      tick();
      tick();
      checks = checks + 1;
      if (bus.busy_out !== 1'b0 || bus.mem_we_out !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL reset_release: busy=%b we=%b, want 0 0", bus.busy_out, bus.mem_we_out);
      end
      $display("reset checked");
   endtask

   task automatic test_basic();
      int d0, exp_done;
      d0 = done_cnt;
      exp_done = 0;
      arm(4, 0, 1'b0, 0);
      for (int i = 0; i < 5; i++) begin
         if (i == 3) exp_done = ncyc + 2;
         send(10 + i, i < 4, i);
      end
      repeat (4) tick();
      checks = checks + 1;
      if (done_cnt != d0 + 1 || last_done_cyc != exp_done) begin
         errors = errors + 1;
         $display("FAIL basic_done: pulses=%0d cyc=%0d, want pulses=1 cyc=%0d",
                  done_cnt - d0, last_done_cyc, exp_done);
      end
      checks = checks + 1;
      if (bus.length_out !== WW'(4) || sb.size() != 0) begin
         errors = errors + 1;
         $display("FAIL basic_length: len=%0d pending=%0d, want len=4 pending=0",
                  bus.length_out, sb.size());
      end
      $display("basic capture done");
   endtask

   task automatic test_decim();
      int d0, exp_done, nw;
      d0 = done_cnt;
      exp_done = 0;
      nw = 0;
      arm(3, 2, 1'b0, 0);
      for (int i = 0; i < 10; i++) begin
         if (i % 3 == 0 && nw < 3) begin
            if (nw == 2) exp_done = ncyc + 2;
            send(i, 1'b1, nw);
            nw++;
         end else begin
            send(i, 1'b0, 0);
         end
         if (i % 2 == 1) tick();
      end
      repeat (3) tick();
      checks = checks + 1;
      if (done_cnt != d0 + 1 || last_done_cyc != exp_done || bus.length_out !== WW'(3)) begin
         errors = errors + 1;
         $display("FAIL decim_done: pulses=%0d cyc=%0d len=%0d, want 1 %0d 3",
                  done_cnt - d0, last_done_cyc, bus.length_out, exp_done);
      end
      checks = checks + 1;
      if (sb.size() != 0) begin
         errors = errors + 1;
         $display("FAIL decim_pending: %0d writes missing, want 0", sb.size());
      end
      $display("decimation done");
   endtask

   task automatic test_trigger();
      int d0;
      d0 = done_cnt;
      arm(2, 0, 1'b1, 0);
      checks = checks + 1;
      if (bus.busy_out !== 1'b1) begin
         errors = errors + 1;
         $display("FAIL trig_busy_armed: busy=%b, want 1", bus.busy_out);
      end
      send(5, 1'b0, 0);
      send(-5, 1'b0, 0);
      send(-1, 1'b0, 0);
      send(3, 1'b1, 0);
      send(7, 1'b1, 1);
      send(9, 1'b0, 0);
      repeat (3) tick();
      checks = checks + 1;
      if (done_cnt != d0 + 1 || bus.length_out !== WW'(2) || sb.size() != 0) begin
         errors = errors + 1;
         $display("FAIL trigger_done: pulses=%0d len=%0d pending=%0d, want 1 2 0",
                  done_cnt - d0, bus.length_out, sb.size());
      end
      $display("trigger done");
   endtask

   task automatic test_clamp_zero();
      int d0, a;
      d0 = done_cnt;
      a = ncyc;
      arm(0, 0, 1'b0, 0);
      send(42, 1'b0, 0);
      send(43, 1'b0, 0);
      tick();
      checks = checks + 1;
      if (done_cnt != d0 + 1 || last_done_cyc != a + 2 || bus.length_out !== '0) begin
         errors = errors + 1;
         $display("FAIL zero_width: pulses=%0d cyc=%0d len=%0d, want 1 %0d 0",
                  done_cnt - d0, last_done_cyc, bus.length_out, a + 2);
      end
      d0 = done_cnt;
      arm(100, 0, 1'b0, 0);
      for (int i = 0; i < MAXD + 4; i++) send(i * 3 - 20, i < MAXD, i);
      repeat (3) tick();
      checks = checks + 1;
      if (done_cnt != d0 + 1 || bus.length_out !== WW'(MAXD) || sb.size() != 0) begin
         errors = errors + 1;
         $display("FAIL clamp: pulses=%0d len=%0d pending=%0d, want 1 %0d 0",
                  done_cnt - d0, bus.length_out, sb.size(), MAXD);
      end
      checks = checks + 1;
      if (bus.mem_addr_out !== WW'(MAXD - 1)) begin
         errors = errors + 1;
         $display("FAIL clamp_last_addr: addr=%0d, want %0d", bus.mem_addr_out, MAXD - 1);
      end
      $display("clamp and zero done");
   endtask

   task automatic test_abort();
      int d0;
      d0 = done_cnt;
      arm(5, 0, 1'b0, 0);
      send(100, 1'b1, 0);
      send(101, 1'b1, 1);
      bus.abort_in = 1'b1;
      send(102, 1'b0, 0);
      bus.abort_in = 1'b0;
      for (int i = 0; i < 4; i++) send(200 + i, 1'b0, 0);
      checks = checks + 1;
      if (done_cnt != d0 || bus.length_out !== WW'(MAXD) || bus.busy_out !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL abort: pulses=%0d len=%0d busy=%b, want 0 %0d 0",
                  done_cnt - d0, bus.length_out, bus.busy_out, MAXD);
      end
      arm(3, 0, 1'b0, 0);
      send(-7, 1'b1, 0);
      send(-8, 1'b1, 1);
      send(-9, 1'b1, 2);
      repeat (3) tick();
      checks = checks + 1;
      if (done_cnt != d0 + 1 || bus.length_out !== WW'(3) || sb.size() != 0) begin
         errors = errors + 1;
         $display("FAIL abort_rearm: pulses=%0d len=%0d pending=%0d, want 1 3 0",
                  done_cnt - d0, bus.length_out, sb.size());
      end
      $display("abort done");
   endtask

   task automatic test_collisions();
      int d0;
      d0 = done_cnt;
      bus.arm_in        = 1'b1;
      bus.abort_in      = 1'b1;
      bus.wave_width_in = WW'(5);
      tick();
      bus.arm_in   = 1'b0;
      bus.abort_in = 1'b0;
      checks = checks + 1;
      if (bus.busy_out !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL arm_abort_busy: busy=%b, want 0", bus.busy_out);
      end
      send(55, 1'b0, 0);
      send(56, 1'b0, 0);
      arm(3, 0, 1'b0, 0);
      send(1, 1'b1, 0);
      bus.arm_in        = 1'b1;
      bus.wave_width_in = WW'(10);
      send(2, 1'b1, 1);
      bus.arm_in = 1'b0;
      send(3, 1'b1, 2);
      send(4, 1'b0, 0);
      send(5, 1'b0, 0);
      repeat (2) tick();
      checks = checks + 1;
      if (done_cnt != d0 + 1 || bus.length_out !== WW'(3) || sb.size() != 0) begin
         errors = errors + 1;
         $display("FAIL arm_while_busy: pulses=%0d len=%0d pending=%0d, want 1 3 0",
                  done_cnt - d0, bus.length_out, sb.size());
      end
      $display("collisions done");
   endtask

   task automatic test_async_reset();
      arm(5, 0, 1'b0, 0);
      send(300, 1'b1, 0);
      send(301, 1'b1, 1);
      checks = checks + 1;
      if (bus.mem_we_out !== 1'b1 || bus.busy_out !== 1'b1) begin
         errors = errors + 1;
         $display("FAIL pre_reset: we=%b busy=%b, want 1 1", bus.mem_we_out, bus.busy_out);
      end
      rst_n = 1'b0;
      #1;
      checks = checks + 1;
      if ({bus.mem_we_out, bus.done_trig_out, bus.busy_out, bus.mem_addr_out,
           bus.mem_data_out, bus.length_out} !== '0) begin
         errors = errors + 1;
         $display("FAIL async_reset: we=%b done=%b busy=%b addr=%0d data=%0d len=%0d, want all 0",
                  bus.mem_we_out, bus.done_trig_out, bus.busy_out, bus.mem_addr_out,
                  bus.mem_data_out, bus.length_out);
      end
      tick();
      rst_n = 1'b1;
      tick();
      arm(2, 0, 1'b0, 0);
      send(8, 1'b1, 0);
      send(9, 1'b1, 1);
      repeat (3) tick();
      checks = checks + 1;
      if (bus.length_out !== WW'(2) || sb.size() != 0) begin
         errors = errors + 1;
         $display("FAIL post_reset: len=%0d pending=%0d, want 2 0", bus.length_out, sb.size());
      end
      $display("async reset done");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_decim();
      test_trigger();
      test_clamp_zero();
      test_abort();
      test_collisions();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
